// File: rtl/br_ckpt_ctrl_pkg.sv
// Shared constants and types for the branch-checkpoint controller and the branch unit.
// The resolve packet is defined here so the branch unit and this block use the same layout.
package br_ckpt_ctrl_pkg;

    localparam int PR_SIZE  = 64;
    localparam int PR_LEN   = $clog2(PR_SIZE);
    localparam int NUM_CKPT = 4;
    localparam int CKPT_LEN = $clog2(NUM_CKPT);

    typedef struct packed {
        logic                valid;
        logic [CKPT_LEN-1:0] tag;
        logic                mispredict;
    } BR_RESOLVE_PACKET;

    // Age of a slot relative to the oldest entry; wraps naturally because NUM_CKPT is a power of two.
    function automatic logic [CKPT_LEN-1:0] ckptOffset(input logic [CKPT_LEN-1:0] slot,
                                                       input logic [CKPT_LEN-1:0] head);
        return slot - head;
    endfunction

endpackage

// File: rtl/br_ckpt_ctrl_age_mask.sv
// Combinational squash mask: marks the checkpoint at tag_i and every live entry younger than it.
module ckpt_age_mask
    import br_ckpt_ctrl_pkg::*;
(
    input  logic [CKPT_LEN-1:0] head_i,
    input  logic [CKPT_LEN-1:0] tail_i,
    input  logic [CKPT_LEN-1:0] tag_i,
    input  logic                full_i,
    output logic [NUM_CKPT-1:0] squash_mask_o
);

    logic [CKPT_LEN:0]   liveLen;
    logic [CKPT_LEN-1:0] tagOff;
    logic [CKPT_LEN-1:0] slotOff [NUM_CKPT];

    // head == tail is ambiguous on its own, so the full flag selects a live length of NUM_CKPT.
    always_comb begin
        liveLen       = full_i ? (CKPT_LEN+1)'(NUM_CKPT) : {1'b0, ckptOffset(tail_i, head_i)};
        tagOff        = ckptOffset(tag_i, head_i);
        squash_mask_o = '0;
        for (int i = 0; i < NUM_CKPT; i++) begin
            slotOff[i]       = ckptOffset(CKPT_LEN'(i), head_i);
            squash_mask_o[i] = (slotOff[i] >= tagOff) && ({1'b0, slotOff[i]} < liveLen);
        end
    end

endmodule

// File: rtl/br_ckpt_ctrl.sv
// Branch-checkpoint controller: allocates checkpoint tags, keeps free-list snapshots
// current with retirement, and restores the free list on a mispredict.
module br_ckpt_ctrl
    import br_ckpt_ctrl_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                br_alloc1,
    input  logic                br_alloc2,
    input  logic [PR_SIZE-1:0]  list_snap1,
    input  logic [PR_SIZE-1:0]  list_snap2,
    input  logic [PR_SIZE-1:0]  retire_free_mask,
    input  logic                br_resolve_valid,
    input  logic [CKPT_LEN-1:0] br_resolve_tag,
    input  logic                br_mispredict,
    output logic                alloc_ok,
    output logic [CKPT_LEN-1:0] ckpt_tag1,
    output logic [CKPT_LEN-1:0] ckpt_tag2,
    output logic                full,
    output logic                restore_valid,
    output logic [PR_SIZE-1:0]  restore_list
);

    logic [PR_SIZE-1:0]  snap_q [NUM_CKPT];
    logic [PR_SIZE-1:0]  snap_d [NUM_CKPT];
    logic [NUM_CKPT-1:0] valid_q, valid_d;
    logic [NUM_CKPT-1:0] resolved_q, resolved_d;
    logic [CKPT_LEN-1:0] head_q, head_d;
    logic [CKPT_LEN-1:0] tail_q, tail_d;
    logic [CKPT_LEN:0]   count_q, count_d;

    BR_RESOLVE_PACKET    resolve;
    logic [1:0]          req;
    logic [CKPT_LEN+1:0] countPlusReq;
    logic                resolveHit;
    logic                mispredictHit;
    logic                correctHit;
    logic                doAlloc;
    logic                write1;
    logic                write2;
    logic                headRetire;
    logic [NUM_CKPT-1:0] squashMask;

    assign resolve = '{valid: br_resolve_valid, tag: br_resolve_tag, mispredict: br_mispredict};

    assign req          = {1'b0, br_alloc1} + {1'b0, br_alloc2};
    assign countPlusReq = {1'b0, count_q} + (CKPT_LEN+2)'(req);
    assign alloc_ok     = countPlusReq <= (CKPT_LEN+2)'(NUM_CKPT);
    assign full         = count_q == (CKPT_LEN+1)'(NUM_CKPT);

    assign resolveHit    = resolve.valid && valid_q[resolve.tag];
    assign mispredictHit = resolveHit && resolve.mispredict;
    assign correctHit    = resolveHit && !resolve.mispredict;

    // Allocations in the mispredict cycle are younger than the bad branch, so they are dropped.
    assign doAlloc = alloc_ok && !mispredictHit;
    assign write1  = doAlloc && br_alloc1;
    assign write2  = doAlloc && br_alloc2;

    assign ckpt_tag1 = tail_q;
    assign ckpt_tag2 = br_alloc1 ? tail_q + CKPT_LEN'(1) : tail_q;

    assign headRetire = valid_q[head_q] && resolved_q[head_q]
                        && !(mispredictHit && (resolve.tag == head_q));

    assign restore_valid = mispredictHit;
    assign restore_list  = mispredictHit ? (snap_q[resolve.tag] | retire_free_mask) : '0;

    ckpt_age_mask u_age_mask (
        .head_i        (head_q),
        .tail_i        (tail_q),
        .tag_i         (resolve.tag),
        .full_i        (full),
        .squash_mask_o (squashMask)
    );

    always_comb begin
        snap_d     = snap_q;
        valid_d    = valid_q;
        resolved_d = resolved_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;

        for (int i = 0; i < NUM_CKPT; i++) begin
            if (valid_q[i]) begin
                snap_d[i] = snap_q[i] | retire_free_mask;
            end
        end

        if (write1) begin
            snap_d[ckpt_tag1]     = list_snap1 | retire_free_mask;
            valid_d[ckpt_tag1]    = 1'b1;
            resolved_d[ckpt_tag1] = 1'b0;
        end
        if (write2) begin
            snap_d[ckpt_tag2]     = list_snap2 | retire_free_mask;
            valid_d[ckpt_tag2]    = 1'b1;
            resolved_d[ckpt_tag2] = 1'b0;
        end

        if (correctHit) begin
            resolved_d[resolve.tag] = 1'b1;
        end
        if (mispredictHit) begin
            valid_d    = valid_d & ~squashMask;
            resolved_d = resolved_d & ~squashMask;
        end

        // Retirement decision uses pre-update flags, so an entry resolving now retires next cycle.
        if (headRetire) begin
            valid_d[head_q]    = 1'b0;
            resolved_d[head_q] = 1'b0;
            head_d             = head_q + CKPT_LEN'(1);
        end

        if (mispredictHit) begin
            tail_d  = resolve.tag;
            count_d = {1'b0, ckptOffset(resolve.tag, head_q)} - (CKPT_LEN+1)'(headRetire);
        end else begin
            if (doAlloc) begin
                tail_d = tail_q + CKPT_LEN'(req);
            end
            count_d = count_q + (doAlloc ? (CKPT_LEN+1)'(req) : '0) - (CKPT_LEN+1)'(headRetire);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_CKPT; i++) begin
                snap_q[i] <= '0;
            end
            valid_q    <= '0;
            resolved_q <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            snap_q     <= snap_d;
            valid_q    <= valid_d;
            resolved_q <= resolved_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

endmodule

// File: tb/tb_br_ckpt_ctrl.sv
// Self-checking bench for br_ckpt_ctrl: each scenario pushes expected output values to a
// scoreboard alongside the sampled DUT value, then drains and compares at the end of the task.
module tb_br_ckpt_ctrl;

    logic        clock;
    logic        reset;
    logic        br_alloc1, br_alloc2;
    logic [63:0] list_snap1, list_snap2, retire_free_mask;
    logic        br_resolve_valid;
    logic [1:0]  br_resolve_tag;
    logic        br_mispredict;
    logic        alloc_ok;
    logic [1:0]  ckpt_tag1, ckpt_tag2;
    logic        full;
    logic        restore_valid;
    logic [63:0] restore_list;

    typedef struct {
        string       name;
        logic [63:0] expv;
        logic [63:0] got;
    } sb_entry_t;

    sb_entry_t sb[$];
    int assertions = 0;
    int failures   = 0;

    br_ckpt_ctrl dut (
        .clock            (clock),
        .reset            (reset),
        .br_alloc1        (br_alloc1),
        .br_alloc2        (br_alloc2),
        .list_snap1       (list_snap1),
        .list_snap2       (list_snap2),
        .retire_free_mask (retire_free_mask),
        .br_resolve_valid (br_resolve_valid),
        .br_resolve_tag   (br_resolve_tag),
        .br_mispredict    (br_mispredict),
        .alloc_ok         (alloc_ok),
        .ckpt_tag1        (ckpt_tag1),
        .ckpt_tag2        (ckpt_tag2),
        .full             (full),
        .restore_valid    (restore_valid),
        .restore_list     (restore_list)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [63:0] observe(input string n);
        if (n == "alloc_ok")      return {63'b0, alloc_ok};
        if (n == "ckpt_tag1")     return {62'b0, ckpt_tag1};
        if (n == "ckpt_tag2")     return {62'b0, ckpt_tag2};
        if (n == "full")          return {63'b0, full};
        if (n == "restore_valid") return {63'b0, restore_valid};
        if (n == "restore_list")  return restore_list;
        return 'x;
    endfunction

    task automatic expectVal(input string n, input logic [63:0] v);
        sb_entry_t e;
        e.name = n;
        e.expv = v;
        e.got  = observe(n);
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic a1, input logic a2,
                                 input logic [63:0] s1, input logic [63:0] s2,
                                 input logic [63:0] mask,
                                 input logic rv, input logic [1:0] rtag, input logic mp);
        br_alloc1        = a1;
        br_alloc2        = a2;
        list_snap1       = s1;
        list_snap2       = s2;
        retire_free_mask = mask;
        br_resolve_valid = rv;
        br_resolve_tag   = rtag;
        br_mispredict    = mp;
        #1;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 64'h0, 64'h0, 64'h0, 0, 2'd0, 0);
    endtask

    task automatic doReset();
        reset = 1'b1;
        idle();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        sb_entry_t e;
        doReset();
        idle();
        expectVal("alloc_ok", 1);
        expectVal("ckpt_tag1", 0);
        expectVal("ckpt_tag2", 0);
        expectVal("full", 0);
        expectVal("restore_valid", 0);
        expectVal("restore_list", 0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            assertions++;
            if (e.got !== e.expv) begin
                failures++;
                $display("[TB] FAIL test_reset %s: got %h expected %h", e.name, e.got, e.expv);
            end
        end
    endtask

    task automatic test_mispredict_restore();
        sb_entry_t e;
        doReset();
        applyStimulus(1, 0, 64'h0F, 64'h0, 64'h0, 0, 2'd0, 0);
        expectVal("alloc_ok", 1);
        expectVal("ckpt_tag1", 0);
        tick();
        applyStimulus(0, 0, 64'h0, 64'h0, 64'h100, 1, 2'd0, 1);
        expectVal("restore_valid", 1);
        expectVal("restore_list", 64'h10F);
        tick();
        applyStimulus(1, 1, 64'h0, 64'h0, 64'h0, 0, 2'd0, 0);
        expectVal("restore_valid", 0);
        expectVal("ckpt_tag1", 0);
        expectVal("ckpt_tag2", 1);
        tick();
        applyStimulus(1, 1, 64'h0, 64'h0, 64'h0, 0, 2'd0, 0);
        expectVal("alloc_ok", 1);
        tick();
        idle();
        expectVal("full", 1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            assertions++;
            if (e.got !== e.expv) begin
                failures++;
                $display("[TB] FAIL test_mispredict_restore %s: got %h expected %h", e.name, e.got, e.expv);
            end
        end
    endtask

    task automatic test_full();
        sb_entry_t e;
        doReset();
        applyStimulus(1, 1, 64'h0, 64'h0, 64'h0, 0, 2'd0, 0);
        expectVal("ckpt_tag1", 0);
        expectVal("ckpt_tag2", 1);
        tick();
        applyStimulus(1, 1, 64'h0, 64'h0, 64'h0, 0, 2'd0, 0);
        expectVal("alloc_ok", 1);
        expectVal("ckpt_tag1", 2);
        expectVal("ckpt_tag2", 3);
        tick();
        applyStimulus(1, 1, 64'h0, 64'h0, 64'h0, 0, 2'd0, 0);
        expectVal("full", 1);
        expectVal("alloc_ok", 0);
        tick();
        applyStimulus(1, 0, 64'h0, 64'h0, 64'h0, 0, 2'd0, 0);
        expectVal("full", 1);
        expectVal("alloc_ok", 0);
        tick();
        idle();
        expectVal("alloc_ok", 1);
        expectVal("full", 1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            assertions++;
            if (e.got !== e.expv) begin
                failures++;
                $display("[TB] FAIL test_full %s: got %h expected %h", e.name, e.got, e.expv);
            end
        end
    endtask

    task automatic test_no_partial_grant();
        sb_entry_t e;
        doReset();
        applyStimulus(0, 1, 64'h0, 64'h0, 64'h0, 0, 2'd0, 0);
        expectVal("ckpt_tag2", 0);
        tick();
        applyStimulus(1, 1, 64'h0, 64'h0, 64'h0, 0, 2'd0, 0);
        expectVal("ckpt_tag1", 1);
        expectVal("ckpt_tag2", 2);
        tick();
        applyStimulus(1, 1, 64'h0, 64'h0, 64'h0, 0, 2'd0, 0);
        expectVal("alloc_ok", 0);
        tick();
        applyStimulus(0, 1, 64'h0, 64'h0, 64'h0, 0, 2'd0, 0);
        expectVal("alloc_ok", 1);
        expectVal("ckpt_tag2", 3);
        expectVal("full", 0);
        tick();
        idle();
        expectVal("full", 1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            assertions++;
            if (e.got !== e.expv) begin
                failures++;
                $display("[TB] FAIL test_no_partial_grant %s: got %h expected %h", e.name, e.got, e.expv);
            end
        end
    endtask

    task automatic test_retire_update();
        sb_entry_t e;
        doReset();
        applyStimulus(1, 0, 64'h0, 64'h0, 64'h0, 0, 2'd0, 0);
        expectVal("ckpt_tag1", 0);
        tick();
        applyStimulus(0, 1, 64'h0, 64'h30, 64'h8, 0, 2'd0, 0);
        expectVal("ckpt_tag2", 1);
        tick();
        applyStimulus(0, 0, 64'h0, 64'h0, 64'h0, 1, 2'd1, 1);
        expectVal("restore_valid", 1);
        expectVal("restore_list", 64'h38);
        tick();
        applyStimulus(0, 0, 64'h0, 64'h0, 64'h0, 1, 2'd0, 1);
        expectVal("restore_valid", 1);
        expectVal("restore_list", 64'h8);
        tick();
        applyStimulus(0, 0, 64'h0, 64'h0, 64'h0, 1, 2'd0, 1);
        expectVal("restore_valid", 0);
        expectVal("restore_list", 64'h0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            assertions++;
            if (e.got !== e.expv) begin
                failures++;
                $display("[TB] FAIL test_retire_update %s: got %h expected %h", e.name, e.got, e.expv);
            end
        end
    endtask

    task automatic test_inorder_retire();
        sb_entry_t e;
        doReset();
        applyStimulus(1, 1, 64'h0, 64'h0, 64'h0, 0, 2'd0, 0);
        expectVal("ckpt_tag2", 1);
        tick();
        applyStimulus(0, 0, 64'h0, 64'h0, 64'h0, 1, 2'd1, 0);
        expectVal("restore_valid", 0);
        tick();
        applyStimulus(0, 0, 64'h0, 64'h0, 64'h0, 1, 2'd0, 0);
        expectVal("restore_valid", 0);
        tick();
        idle();
        tick();
        applyStimulus(0, 0, 64'h0, 64'h0, 64'h0, 1, 2'd0, 1);
        expectVal("restore_valid", 0);
        tick();
        applyStimulus(1, 1, 64'h0, 64'h0, 64'h0, 1, 2'd1, 1);
        expectVal("restore_valid", 0);
        expectVal("alloc_ok", 1);
        expectVal("ckpt_tag1", 2);
        expectVal("ckpt_tag2", 3);
        tick();
        applyStimulus(1, 1, 64'h0, 64'h0, 64'h0, 0, 2'd0, 0);
        expectVal("alloc_ok", 1);
        expectVal("ckpt_tag1", 0);
        expectVal("ckpt_tag2", 1);
        tick();
        idle();
        expectVal("full", 1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            assertions++;
            if (e.got !== e.expv) begin
                failures++;
                $display("[TB] FAIL test_inorder_retire %s: got %h expected %h", e.name, e.got, e.expv);
            end
        end
    endtask

    task automatic test_squash_alloc();
        sb_entry_t e;
        doReset();
        applyStimulus(1, 1, 64'h0, 64'h0, 64'h0, 0, 2'd0, 0);
        tick();
        applyStimulus(1, 0, 64'h0, 64'h0, 64'h0, 0, 2'd0, 0);
        expectVal("ckpt_tag1", 2);
        tick();
        applyStimulus(1, 0, 64'hAA, 64'h0, 64'h0, 1, 2'd1, 1);
        expectVal("restore_valid", 1);
        tick();
        applyStimulus(1, 0, 64'h0, 64'h0, 64'h0, 0, 2'd0, 0);
        expectVal("restore_valid", 0);
        expectVal("ckpt_tag1", 1);
        tick();
        applyStimulus(1, 1, 64'h0, 64'h0, 64'h0, 0, 2'd0, 0);
        expectVal("alloc_ok", 1);
        expectVal("ckpt_tag1", 2);
        expectVal("ckpt_tag2", 3);
        tick();
        idle();
        expectVal("full", 1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            assertions++;
            if (e.got !== e.expv) begin
                failures++;
                $display("[TB] FAIL test_squash_alloc %s: got %h expected %h", e.name, e.got, e.expv);
            end
        end
    endtask

    task automatic test_reset_mid();
        sb_entry_t e;
        doReset();
        applyStimulus(1, 1, 64'h0, 64'h0, 64'h0, 0, 2'd0, 0);
        tick();
        applyStimulus(1, 0, 64'h0, 64'h0, 64'h0, 0, 2'd0, 0);
        tick();
        reset = 1'b1;
        applyStimulus(0, 0, 64'h0, 64'h0, 64'h5, 1, 2'd1, 1);
        tick();
        reset = 1'b0;
        idle();
        expectVal("alloc_ok", 1);
        expectVal("ckpt_tag1", 0);
        expectVal("ckpt_tag2", 0);
        expectVal("full", 0);
        expectVal("restore_valid", 0);
        expectVal("restore_list", 0);
        applyStimulus(1, 1, 64'h0, 64'h0, 64'h0, 0, 2'd0, 0);
        expectVal("ckpt_tag1", 0);
        expectVal("ckpt_tag2", 1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            assertions++;
            if (e.got !== e.expv) begin
                failures++;
                $display("[TB] FAIL test_reset_mid %s: got %h expected %h", e.name, e.got, e.expv);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        idle();
        tick();
        test_reset();
        test_mispredict_restore();
        test_full();
        test_no_partial_grant();
        test_retire_update();
        test_inorder_retire();
        test_squash_alloc();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/br_ckpt_ctrl.md
# br_ckpt_ctrl

Branch-checkpoint controller for the physical-register free list in the rename/dispatch stage. It allocates up to two checkpoint tags per cycle for dispatching branches and captures the free-list bitmap at each branch. It keeps those snapshots current as retirement frees registers. On a mispredict it drives the free list's restore port (`mispredictSet`/`listIn`) and squashes the mispredicted checkpoint and all younger ones.

## Interface
- `PR_SIZE`, 64, number of physical registers (bitmap width).
- `NUM_CKPT`, 4, checkpoint entries; power of two.
- `CKPT_LEN`, $clog2(NUM_CKPT), tag width.

- `clock`  in  1  single clock, all state updates on posedge.
- `reset`  in  1  synchronous, active-high.
- `br_alloc1`, `br_alloc2`  in  1  branch dispatching in slot 1 / slot 2.
- `list_snap1`, `list_snap2`  in  PR_SIZE  free-list bitmap after slot-1 / slot-2 allocation (the free list's `listOut1`/`listOut2`).
- `retire_free_mask`  in  PR_SIZE  registers freed by retirement this cycle.
- `br_resolve_valid`  in  1  a branch resolves this cycle.
- `br_resolve_tag`  in  CKPT_LEN  its checkpoint tag.
- `br_mispredict`  in  1  qualifies the resolve as a mispredict.
- `alloc_ok`  out  1  requested allocations fit; combinational.
- `ckpt_tag1`, `ckpt_tag2`  out  CKPT_LEN  tags granted to slot 1 / slot 2.
- `full`  out  1  count == NUM_CKPT.
- `restore_valid`  out  1  drives the free list's `mispredictSet`.
- `restore_list`  out  PR_SIZE  drives the free list's `listIn`.

## Operation
- State: circular buffer `snap[NUM_CKPT]`, `valid[]`, `resolved[]`, `head` (oldest), `tail` (next free), `count` (0..NUM_CKPT).
- Allocation:
  - `req` = `br_alloc1` + `br_alloc2`.
  - `alloc_ok` = (count + req <= NUM_CKPT).
  - If `alloc_ok` and no mispredict:
    - The first requesting slot gets `tail` and the second gets `tail+1`, modulo NUM_CKPT.
    - Only `br_alloc2`: `ckpt_tag2` = `tail`.
    - Each written entry stores its `list_snap | retire_free_mask`; `valid`=1, `resolved`=0.
    - `tail += req`, `count += req`.
  - If `!alloc_ok`: nothing is written, and dispatch stalls both slots.
- Retire update: every valid entry not written this cycle does `snap |= retire_free_mask` each cycle.
- Correct resolve (tag valid, `!br_mispredict`): set `resolved[tag]`; branches may resolve out of order.
- Head retire: if `valid[head] && resolved[head]`, clear the entry and do `head++`, `count--`. At most one per cycle, using the pre-update state.
- Mispredict (tag valid, `br_mispredict`):
  - `restore_valid`=1 and `restore_list` = `snap[tag] | retire_free_mask`, both combinational the same cycle. The free list loads it at the next edge.
  - At that edge, the entry at `tag` and every entry younger than it become invalid, and their `resolved` flags clear.
  - `tail` = `tag` and `count` = (tag − head) mod NUM_CKPT. When tag == head, count = 0.
  - Same-cycle allocations are ignored because they are younger.
  - Head retire still applies that cycle if head != tag.
- A resolve whose tag is not valid is ignored, and `restore_valid` stays 0.
- `ckpt_tag*` are meaningful only when the matching `br_alloc*` and `alloc_ok` are both high.

## Timing
- Reset values: head=tail=count=0, all `valid`/`resolved` clear, `full`=0, `restore_valid`=0, `restore_list`=0, `ckpt_tag1`=`ckpt_tag2`=0, `alloc_ok`=1 when no request.
- `alloc_ok`, tags, `restore_*`: zero-latency combinational from inputs and registered state.
- All state changes become visible the cycle after the edge.
- Wrap-around: tags and pointers wrap modulo NUM_CKPT.
- `full` and `count` come from the counter, so a full buffer is distinguished from an empty one with head==tail.
- A two-slot request with one free entry is refused in full; there is no partial grant.
- Reset asserted mid-operation overrides every input, including a concurrent mispredict, and returns to reset values at the next edge.

## Structure
- The shared package holds `PR_SIZE`, `PR_LEN`, `NUM_CKPT`, `CKPT_LEN`, and a `BR_RESOLVE_PACKET` typedef (valid, tag, mispredict) that the branch unit reuses.
- There is one sub-module, `ckpt_age_mask`. It is combinational: from head, tail and tag it produces the NUM_CKPT-bit mask of the squashed entries (tag and younger).

## Test plan
- Reset; `br_alloc1` with snap1=64'h0F → tag1=0. Next cycle, mispredict tag 0 with `retire_free_mask`=64'h100 → `restore_valid`=1, `restore_list`=64'h10F. After the edge, count=0.
- Two dual allocations → tags (0,1) then (2,3), and `full`=1. A third dual request → `alloc_ok`=0 and state is unchanged. A single request is also refused.
- Alloc tag 0 with snap 64'h0. Next cycle, mask 64'h8. Then mispredict tag 0 with mask 0 → `restore_list`=64'h8.
- Alloc tags 0 and 1; resolve 1 correct → head=0, count=2. Resolve 0 correct → next cycle head=1, count=1, then head=2, count=0.
- Tags 0–2 live; mispredict tag 1 together with `br_alloc1` → alloc ignored; next cycle count=1, tail=1, and the next allocation gets tag 1.
- Three entries live, then `reset`=1 with a concurrent mispredict → `restore_valid` and every other output at its reset value after the edge, and the next allocation gets tag 0.
